// File: rtl/sistema_climatico_zonas.sv
// Multi-zone cabin climate supervisor: per-zone fan hysteresis, over-temperature
// persistence with a latched global alarm, and a 4-digit multiplexed display.
//   state       | meaning
//   VENT_OFF    | zone fan disabled
//   VENT_ON     | zone fan enabled
//   ALM_NORMAL  | no over-temperature condition latched
//   ALM_ALARM   | alarm latched until every zone cools below T_ALARM-HYST
module sistema_climatico_zonas #(
  parameter int ZONES    = 2,
  parameter int TEMP_W   = 7,
  parameter int T_ON     = 25,
  parameter int HYST     = 2,
  parameter int T_ALARM  = 40,
  parameter int PERSIST  = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ZONES*TEMP_W-1:0]   temperatura,
  input  logic [ZONES-1:0]          presencia,
  input  logic                      ignicion,
  output logic [ZONES-1:0]          ventilacion,
  output logic                      alarma,
  output logic [1:0]                alerta,
  output logic [7:0]                catodo,
  output logic [3:0]                seleccion
);

  localparam logic [0:0] VENT_OFF   = 1'b0;
  localparam logic [0:0] VENT_ON    = 1'b1;
  localparam logic [0:0] ALM_NORMAL = 1'b0;
  localparam logic [0:0] ALM_ALARM  = 1'b1;

  localparam int T_OFF = (T_ON >= HYST) ? T_ON - HYST : 0;
  localparam int T_CLR = (T_ALARM >= HYST) ? T_ALARM - HYST : 0;
  localparam logic [7:0] T_ON_L    = 8'(T_ON);
  localparam logic [7:0] T_OFF_L   = 8'(T_OFF);
  localparam logic [7:0] T_ALARM_L = 8'(T_ALARM);
  localparam logic [7:0] T_CLR_L   = 8'(T_CLR);
  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] PERSIST_L = CW'(PERSIST);
  localparam int IW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [ZONES*TEMP_W-1:0] temp_q;
  logic [ZONES-1:0]        pres_q;
  logic                    ign_q;
  logic [ZONES-1:0]        vent_q, vent_d;
  logic [CW-1:0]           cnt_q [ZONES];
  logic [CW-1:0]           cnt_d [ZONES];
  logic [0:0]              alarm_q, alarm_d;
  logic [1:0]              alerta_q, alerta_d;
  logic [7:0]              max_q, max_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [SW-1:0]           scan_q, scan_d;
  logic [1:0]              digit_q, digit_d;
  logic [7:0]              cat_q, cat_d;
  logic [7:0]              tz;
  logic                    any_cnt, any_full, all_clear;
  logic [3:0]              hund, tens, units, dval;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  always_comb begin
    vent_d    = vent_q;
    any_cnt   = 1'b0;
    any_full  = 1'b0;
    all_clear = 1'b1;
    tz        = '0;
    for (int z = 0; z < ZONES; z++) begin
      tz = 8'(temp_q[z*TEMP_W +: TEMP_W]);
      if (vent_q[z] == VENT_OFF) begin
        if (ign_q && pres_q[z] && tz >= T_ON_L) vent_d[z] = VENT_ON;
      end else if (!ign_q || !pres_q[z] || tz < T_OFF_L) begin
        vent_d[z] = VENT_OFF;
      end
      // counter tracks the run of consecutive hot samples, independent of ignition
      if (tz >= T_ALARM_L)
        cnt_d[z] = (cnt_q[z] == PERSIST_L) ? cnt_q[z] : cnt_q[z] + CW'(1);
      else
        cnt_d[z] = '0;
      if (cnt_d[z] != '0)       any_cnt   = 1'b1;
      if (cnt_d[z] == PERSIST_L) any_full  = 1'b1;
      if (tz >= T_CLR_L)        all_clear = 1'b0;
    end
    if (alarm_q == ALM_ALARM) alarm_d = all_clear ? ALM_NORMAL : ALM_ALARM;
    else                      alarm_d = any_full ? ALM_ALARM : ALM_NORMAL;
    if (alarm_d == ALM_ALARM) alerta_d = 2'b11;
    else if (any_cnt)         alerta_d = 2'b10;
    else if (|vent_d)         alerta_d = 2'b01;
    else                      alerta_d = 2'b00;
  end

  always_comb begin
    max_d = 8'(temp_q[0 +: TEMP_W]);
    idx_d = '0;
    for (int z = 1; z < ZONES; z++) begin
      if (8'(temp_q[z*TEMP_W +: TEMP_W]) > max_d) begin
        max_d = 8'(temp_q[z*TEMP_W +: TEMP_W]);
        idx_d = IW'(z);
      end
    end
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      scan_d  = scan_q + SW'(1);
      digit_d = digit_q;
    end
    hund  = 4'(max_q / 8'd100);
    tens  = 4'((max_q / 8'd10) % 8'd10);
    units = 4'(max_q % 8'd10);
    // the segment pattern follows the digit being enabled on the same edge
    case (digit_d)
      2'd0:    dval = units;
      2'd1:    dval = tens;
      2'd2:    dval = (hund == 4'd0) ? 4'hF : hund;
      default: dval = 4'(idx_q);
    endcase
    cat_d = seg7(dval);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      temp_q   <= '0;
      pres_q   <= '0;
      ign_q    <= 1'b0;
      vent_q   <= '0;
      for (int z = 0; z < ZONES; z++) cnt_q[z] <= '0;
      alarm_q  <= ALM_NORMAL;
      alerta_q <= 2'b00;
      max_q    <= '0;
      idx_q    <= '0;
      scan_q   <= '0;
      digit_q  <= 2'd0;
      cat_q    <= 8'hFF;
    end else begin
      temp_q   <= temperatura;
      pres_q   <= presencia;
      ign_q    <= ignicion;
      vent_q   <= vent_d;
      for (int z = 0; z < ZONES; z++) cnt_q[z] <= cnt_d[z];
      alarm_q  <= alarm_d;
      alerta_q <= alerta_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      scan_q   <= scan_d;
      digit_q  <= digit_d;
      cat_q    <= cat_d;
    end
  end

  assign ventilacion = vent_q;
  assign alarma      = alarm_q;
  assign alerta      = alerta_q;
  assign catodo      = cat_q;
  assign seleccion   = ~(4'b0001 << digit_q);

endmodule

// File: tb/tb_sistema_climatico_zonas.sv
// Bench for sistema_climatico_zonas: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_sistema_climatico_zonas;
  localparam int Z = 2, W = 7, SD = 4, PERS = 4, TON = 25, HY = 2, TAL = 40;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [Z*W-1:0] temperatura = '0;
  logic [Z-1:0]   presencia = '0;
  logic           ignicion = 1'b0;
  logic [Z-1:0]   ventilacion;
  logic           alarma;
  logic [1:0]     alerta;
  logic [7:0]     catodo;
  logic [3:0]     seleccion;

  sistema_climatico_zonas #(
    .ZONES(Z), .TEMP_W(W), .T_ON(TON), .HYST(HY), .T_ALARM(TAL),
    .PERSIST(PERS), .SCAN_DIV(SD)
  ) dut (
    .clk(clk), .rst(rst), .temperatura(temperatura), .presencia(presencia),
    .ignicion(ignicion), .ventilacion(ventilacion), .alarma(alarma),
    .alerta(alerta), .catodo(catodo), .seleccion(seleccion)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // behavioural model: sampled inputs, then outputs derived from them
  int r_t [Z];
  bit r_p [Z];
  bit r_ign;
  bit m_fan [Z];
  int m_run [Z];
  bit m_alarm;
  int m_alerta, m_max, m_idx, m_scan, m_digit, m_cat;
  bit any_run, any_full, all_cool, any_fan;

  function automatic int seg_of(input int v);
    case (v)
      0: return 'hC0; 1: return 'hF9; 2: return 'hA4; 3: return 'hB0; 4: return 'h99;
      5: return 'h92; 6: return 'h82; 7: return 'hF8; 8: return 'h80; 9: return 'h90;
      default: return 'hFF;
    endcase
  endfunction

  task automatic model_reset();
    for (int z = 0; z < Z; z++) begin
      r_t[z] = 0; r_p[z] = 0; m_fan[z] = 0; m_run[z] = 0;
    end
    r_ign = 0; m_alarm = 0; m_alerta = 0; m_max = 0; m_idx = 0;
    m_scan = 0; m_digit = 0; m_cat = 'hFF;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else begin
        any_run = 0; any_full = 0; all_cool = 1; any_fan = 0;
        for (int z = 0; z < Z; z++) begin
          if (!m_fan[z]) m_fan[z] = r_ign && r_p[z] && (r_t[z] >= TON);
          else           m_fan[z] = r_ign && r_p[z] && (r_t[z] >= TON - HY);
          m_run[z] = (r_t[z] >= TAL) ? ((m_run[z] + 1 > PERS) ? PERS : m_run[z] + 1) : 0;
          if (m_run[z] > 0)     any_run = 1;
          if (m_run[z] == PERS) any_full = 1;
          if (r_t[z] >= TAL - HY) all_cool = 0;
          if (m_fan[z])         any_fan = 1;
        end
        m_alarm  = m_alarm ? !all_cool : any_full;
        m_alerta = m_alarm ? 3 : any_run ? 2 : any_fan ? 1 : 0;
        if (m_scan == SD - 1) begin m_scan = 0; m_digit = (m_digit + 1) % 4; end
        else m_scan++;
        case (m_digit)
          0: m_cat = seg_of(m_max % 10);
          1: m_cat = seg_of((m_max / 10) % 10);
          2: m_cat = (m_max >= 100) ? seg_of(m_max / 100) : 'hFF;
          default: m_cat = seg_of(m_idx);
        endcase
        m_max = r_t[0]; m_idx = 0;
        for (int z = 1; z < Z; z++) if (r_t[z] > m_max) begin m_max = r_t[z]; m_idx = z; end
        for (int z = 0; z < Z; z++) begin
          r_t[z] = int'(temperatura[z*W +: W]);
          r_p[z] = presencia[z];
        end
        r_ign = ignicion;
      end
    end
  end

  initial begin
    logic [Z-1:0] ev;
    logic [3:0]   es;
    forever begin
      @(negedge clk);
      if (cmp_en && rst) begin
        for (int z = 0; z < Z; z++) ev[z] = m_fan[z];
        es = ~(4'b0001 << m_digit);
        chk("model_vent", ventilacion, ev);
        chk("model_alarma", alarma, m_alarm);
        chk("model_alerta", alerta, m_alerta);
        chk("model_catodo", catodo, m_cat);
        chk("model_sel", seleccion, es);
      end
    end
  end

  task automatic set_t(input int t0, input int t1);
    temperatura[0 +: W] = 7'(t0);
    temperatura[W +: W] = 7'(t1);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_vent"}, ventilacion, 0);
    chk({nm, "_alarma"}, alarma, 0);
    chk({nm, "_alerta"}, alerta, 0);
    chk({nm, "_catodo"}, catodo, 'hFF);
    chk({nm, "_sel"}, seleccion, 'hE);
  endtask

  // reset, load temps, then walk one full scan with literal segment expectations
  task automatic disp_window(input int t0, input int t1,
                             input int eu, input int et, input int eh, input int ei);
    int d, e;
    logic [3:0] es;
    @(negedge clk);
    #3 rst = 1'b0;
    set_t(t0, t1);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      d  = (k / 4) % 4;
      e  = (d == 0) ? eu : (d == 1) ? et : (d == 2) ? eh : ei;
      es = ~(4'b0001 << d);
      chk("disp_catodo", catodo, e);
      chk("disp_sel", seleccion, es);
    end
  endtask

  int v;

  initial begin
    tick(2);
    check_reset_outputs("reset");
    cmp_en = 1'b1;
    rst = 1'b1;

    // fan hysteresis
    ignicion = 1'b1; presencia = 2'b01; set_t(25, 20);
    tick(2);
    chk("t1_vent_on", ventilacion, 2'b01);
    chk("t1_alerta", alerta, 2'b01);
    set_t(23, 20); tick(2);
    chk("t1_vent_hold", ventilacion, 2'b01);
    set_t(22, 20); tick(2);
    chk("t1_vent_off", ventilacion, 2'b00);
    chk("t1_alerta_idle", alerta, 2'b00);

    // three hot cycles do not qualify
    set_t(22, 40); tick(2);
    chk("t2_prealarm", alerta, 2'b10);
    tick(1); set_t(22, 39); tick(1);
    chk("t2_no_alarm", alarma, 0);
    chk("t2_still_pre", alerta, 2'b10);
    tick(1);
    chk("t2_alerta_back", alerta, 2'b00);
    chk("t2_alarm_low", alarma, 0);

    // four hot cycles raise the alarm, then hysteresis on release
    set_t(22, 40); tick(4); set_t(22, 38); tick(1);
    chk("t2_alarm", alarma, 1);
    chk("t2_alerta_alarm", alerta, 2'b11);
    tick(2);
    chk("t3_alarm_hold", alarma, 1);
    set_t(22, 37); tick(2);
    chk("t3_alarm_clear", alarma, 0);

    // ignition drop kills the fan while the alarm path keeps counting
    set_t(30, 37); tick(2);
    chk("t5_vent_on", ventilacion, 2'b01);
    ignicion = 1'b0; set_t(30, 45); tick(2);
    chk("t5_vent_off", ventilacion, 2'b00);
    chk("t5_alerta_pre", alerta, 2'b10);
    tick(3);
    chk("t5_alarm", alarma, 1);
    chk("t5_alerta_alarm", alerta, 2'b11);

    // asynchronous reset mid-alarm and mid-scan, then re-qualification
    tick(2);
    #3 rst = 1'b0;
    #1 check_reset_outputs("t6_async");
    @(negedge clk);
    rst = 1'b1;
    chk("t6_sel_release", seleccion, 'hE);
    tick(4);
    chk("t6_alarm_wait", alarma, 0);
    tick(1);
    chk("t6_alarm_requal", alarma, 1);

    // display: tie keeps zone 0, leading-zero blanking, higher zone index
    ignicion = 1'b1; presencia = 2'b11;
    disp_window(105, 105, 'h92, 'hC0, 'hF9, 'hC0);
    disp_window(9, 9, 'h90, 'hC0, 'hFF, 'hC0);
    disp_window(7, 58, 'h80, 'h92, 'hFF, 'hF9);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      for (int z = 0; z < Z; z++) begin
        if ($urandom_range(0, 3) == 0) begin
          v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127))
                                          : int'($urandom_range(20, 44));
          temperatura[z*W +: W] = 7'(v);
        end
        if ($urandom_range(0, 15) == 0) presencia[z] = ~presencia[z];
      end
      if ($urandom_range(0, 19) == 0) ignicion = ~ignicion;
      if ($urandom_range(0, 599) == 0) begin
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end

    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
